bcd_to_binary_serial: RTL and testbench

Sequential BCD-to-binary converter. It accepts a three-digit packed BCD value (000–999) with a start pulse and produces the 10-bit binary equivalent. It works iteratively using reverse double-dabble: shift right, then subtract 3 from any BCD nibble that is ≥ 8. It is the inverse path of the binary-to-BCD display logic and turns decimal switch entry into a binary operand for the adder datapath.

---
 rtl/bcd_to_binary_serial.sv | 110 +++++++++++
 tb/tb_bcd_to_binary_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble.
// Takes three packed BCD digits with a start pulse and, after ten iterations,
// presents the 10-bit binary value on bin_out with a one-cycle done pulse.
// Optional digit checking is enabled by defining BCD2BIN_CHECK_EN; when the
// macro is undefined every start is accepted and invalid is tied low.
module bcd_to_binary_serial (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bcd_in,
  output logic [9:0]  bin_out,
  output logic        busy,
  output logic        done,
  output logic        invalid
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [21:0] r_work;        // {bcd[11:0], bin[9:0]}
  logic [21:0] w_work_shift;
  logic [21:0] w_work_next;
  logic [3:0]  r_cnt;
  logic [9:0]  r_bin;
  logic        w_digits_ok;
  logic        w_accept;
  logic        w_last;

`ifdef BCD2BIN_CHECK_EN
  logic r_invalid;

  // Each BCD digit must be 0..9 for the start to be accepted.
  always_comb begin
    w_digits_ok = (bcd_in[11:8] <= 4'd9) && (bcd_in[7:4] <= 4'd9) && (bcd_in[3:0] <= 4'd9);
  end

  // Flag a rejected start for exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_invalid <= 1'b0;
    end else begin
      r_invalid <= (r_state == StIdle) && start && !w_digits_ok;
    end
  end

  assign invalid = r_invalid;
`else
  assign w_digits_ok = 1'b1;
  assign invalid     = 1'b0;
`endif

  assign w_accept = (r_state == StIdle) && start && w_digits_ok;
  assign w_last   = (r_state == StConv) && (r_cnt == 4'd9);

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that reached 8 or more back down by 3.
  always_comb begin
    w_work_shift = {1'b0, r_work[21:1]};
    w_work_next  = w_work_shift;
    if (w_work_shift[21:18] >= 4'd8) w_work_next[21:18] = w_work_shift[21:18] - 4'd3;
    if (w_work_shift[17:14] >= 4'd8) w_work_next[17:14] = w_work_shift[17:14] - 4'd3;
    if (w_work_shift[13:10] >= 4'd8) w_work_next[13:10] = w_work_shift[13:10] - 4'd3;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only looked at in idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StConv;
      StConv:  if (w_last)   w_state_next = StDone;
      StDone:                w_state_next = StIdle;
      default:               w_state_next = StIdle;
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    busy = (r_state == StConv);
    done = (r_state == StDone);
  end

  // Working register, iteration counter and held result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_work <= 22'd0;
      r_cnt  <= 4'd0;
      r_bin  <= 10'd0;
    end else if (w_accept) begin
      r_work <= {bcd_in, 10'd0};
      r_cnt  <= 4'd0;
    end else if (r_state == StConv) begin
      r_work <= w_work_next;
      r_cnt  <= r_cnt + 4'd1;
      if (w_last) r_bin <= w_work_next[9:0];
    end
  end

  assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Self-checking bench for bcd_to_binary_serial: a cycle-timeline model derived
// from decimal arithmetic is compared against the DUT on every falling edge,
// and directed conversions pin the model with literal expected values.
module tb_bcd_to_binary_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        invalid;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: m_age counts edges since the accepting edge (-1 when idle).
  int m_age = -1;
  int m_val = 0;
  int m_bin = 0;
  bit m_inv = 1'b0;

  bcd_to_binary_serial dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  always #5 clock = ~clock;

  function automatic bit digits_ok(input logic [11:0] b);
    return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int to_dec(input logic [11:0] b);
    return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic bit check_en_build();
`ifdef BCD2BIN_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural timeline model.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_age <= -1;
      m_bin <= 0;
      m_inv <= 1'b0;
    end else begin
      m_inv <= 1'b0;
      if (m_age >= 0) begin
        if (m_age == 10) m_age <= -1;
        else             m_age <= m_age + 1;
        if (m_age == 9)  m_bin <= m_val;
      end else if (start) begin
        if (digits_ok(bcd_in) || !check_en_build()) begin
          m_age <= 0;
          m_val <= to_dec(bcd_in);
        end else begin
          m_inv <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("bin_out", int'(bin_out), m_bin);
      check("busy", int'(busy), int'(m_age >= 0 && m_age < 10));
      check("done", int'(done), int'(m_age == 10));
      check("invalid", int'(invalid), int'(m_inv));
    end
  end

  // Start a conversion, check 10-edge latency and the literal result.
  task automatic run(input logic [11:0] b, input int exp);
    int k;
    bit seen;
    @(negedge clock);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    bcd_in = ~b;  // must not affect the running conversion
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      seen = done;
    end
    check("latency", k, 10);
    check("result", int'(bin_out), exp);
    @(negedge clock);
    check("done_fall", int'(done), 0);
  endtask

  initial begin
    int dcount;
    #1 reset = 1'b1;
    #1;
    check("rst_bin", int'(bin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_inv", int'(invalid), 0);
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;

    run(12'h999, 999);
    run(12'h000, 0);
    run(12'h019, 19);
    run(12'h258, 258);

`ifdef BCD2BIN_CHECK_EN
    @(negedge clock);
    start  = 1'b1;
    bcd_in = 12'h0A5;
    @(negedge clock);
    start  = 1'b0;
    check("inv_pulse", int'(invalid), 1);
    check("inv_busy", int'(busy), 0);
    @(negedge clock);
    check("inv_fall", int'(invalid), 0);
    check("inv_hold", int'(bin_out), 258);
`endif

    // Second start during conversion is ignored.
    @(negedge clock);
    start  = 1'b1;
    bcd_in = 12'h123;
    @(negedge clock);
    start  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    start  = 1'b1;  // sampled at E3
    bcd_in = 12'h456;
    @(negedge clock);
    start  = 1'b0;
    dcount = 0;
    repeat (16) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("one_done", dcount, 1);
    check("ignore_2nd", int'(bin_out), 123);

    // Reset mid-conversion discards the partial result.
    @(negedge clock);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_bin", int'(bin_out), 0);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("no_done_777", dcount, 0);
    run(12'h042, 42);

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
